ysyx_24070016_regfile_sb: RTL and testbench

//  Parametrised multi-read-port register file with write-to-read bypass and a per-register

---
 rtl/ysyx_24070016_regfile_sb_pkg.sv | 20 ++
 rtl/ysyx_24070016_sb_counter.sv | 48 ++++
 rtl/ysyx_24070016_regfile_sb.sv | 129 ++++++++++++
 tb/tb_ysyx_24070016_regfile_sb.sv | 378 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_24070016_regfile_sb_pkg.sv
// Shared defaults and types for the NPC register file with pending-write scoreboard.
package ysyx_24070016_regfile_sb_pkg;

    // Default geometry of the GPR file.
    localparam int DEF_ADDR_WIDTH = 5;
    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_NREAD      = 2;
    localparam int DEF_CNT_WIDTH  = 2;

    // Index of the architectural zero register.
    localparam int REG_ZERO = 0;

    // Where a read port takes its data from in a given cycle.
    typedef enum logic [1:0] {
        SRC_ZERO   = 2'd0,
        SRC_BYPASS = 2'd1,
        SRC_ARRAY  = 2'd2
    } rd_src_e;

endpackage

// File: rtl/ysyx_24070016_sb_counter.sv
// One saturating up/down pending-write counter for a single register.
// clr (flush) beats inc/dec; inc and dec together cancel; never wraps either way.
module ysyx_24070016_sb_counter
    import ysyx_24070016_regfile_sb_pkg::*;
#(
    parameter int CNT_WIDTH = DEF_CNT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 inc,
    input  logic                 dec,
    input  logic                 clr,
    output logic [CNT_WIDTH-1:0] cnt,
    output logic                 full
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    logic [CNT_WIDTH-1:0] cnt_d;
    logic [CNT_WIDTH-1:0] cnt_q;

    // Next count: clear, then saturating increment/decrement.
    // NOTE: always_comb uses blocking '=' so later lines see earlier results; flops below use '<=' only.
    always_comb begin
        // NOTE: every path starts from this default, so no latch can be inferred.
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && !dec && cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
        end else if (dec && !inc && cnt_q != '0) begin
            cnt_d = cnt_q - CNT_WIDTH'(1);
        end
    end

    // Counter state with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt  = cnt_q;
    assign full = (cnt_q == CNT_MAX);

endmodule

// File: rtl/ysyx_24070016_regfile_sb.sv
// Multi-read-port GPR file with write-to-read bypass and a per-register pending-write
// scoreboard. Issue reserves a destination, writeback commits data and releases it.
module ysyx_24070016_regfile_sb
    import ysyx_24070016_regfile_sb_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int NREAD      = DEF_NREAD,
    parameter int CNT_WIDTH  = DEF_CNT_WIDTH,
    parameter int ZERO_REG   = 1,
    parameter int BYPASS     = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NREAD*ADDR_WIDTH-1:0] raddr,
    output logic [NREAD*DATA_WIDTH-1:0] rdata,
    output logic [NREAD-1:0]            rvalid,
    input  logic                        wen,
    input  logic [ADDR_WIDTH-1:0]       waddr,
    input  logic [DATA_WIDTH-1:0]       wdata,
    input  logic                        iss_valid,
    input  logic [ADDR_WIDTH-1:0]       iss_rd,
    output logic                        iss_ready,
    input  logic                        flush
);

    localparam int                    NREG     = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] ZERO_IDX = ADDR_WIDTH'(REG_ZERO);

    logic [DATA_WIDTH-1:0] rf_d [NREG];
    logic [DATA_WIDTH-1:0] rf_q [NREG];
    logic [CNT_WIDTH-1:0]  cnt  [NREG];
    logic [NREG-1:0]       full;
    logic                  write_en;

    // A write to the hardwired zero register is dropped entirely.
    assign write_en = wen && !(ZERO_REG != 0 && waddr == ZERO_IDX);

    // Reservations to r0 are always accepted (and never counted) when it is hardwired.
    assign iss_ready = !full[iss_rd] || (ZERO_REG != 0 && iss_rd == ZERO_IDX);

    // Next data array: writeback overwrites one entry.
    always_comb begin
        rf_d = rf_q;
        if (write_en) begin
            rf_d[waddr] = wdata;
        end
    end

    // Data array state; reset zeroes every register.
    // NOTE: the array is reset deliberately because reads must return zero right after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                rf_q[i] <= '0;
            end
        end else begin
            rf_q <= rf_d;
        end
    end

    // One pending-write counter per register.
    for (genvar r = 0; r < NREG; r++) begin : g_cnt
        logic inc;
        logic dec;

        assign inc = iss_valid && iss_ready && iss_rd == ADDR_WIDTH'(r)
                     && !(ZERO_REG != 0 && r == REG_ZERO);
        // An untracked writeback (count already zero) leaves the counter alone.
        assign dec = write_en && waddr == ADDR_WIDTH'(r) && cnt[r] != '0;

        ysyx_24070016_sb_counter #(
            .CNT_WIDTH (CNT_WIDTH)
        ) u_cnt (
            .clk  (clk),
            .rst  (rst),
            .inc  (inc),
            .dec  (dec),
            .clr  (flush),
            .cnt  (cnt[r]),
            .full (full[r])
        );
    end

    // Combinational read ports.
    for (genvar i = 0; i < NREAD; i++) begin : g_read
        logic [ADDR_WIDTH-1:0] a;
        rd_src_e               src;
        logic [DATA_WIDTH-1:0] port_data;
        logic                  port_valid;

        assign a = raddr[i*ADDR_WIDTH +: ADDR_WIDTH];

        // Pick the data source: zero register, same-cycle writeback, or the array.
        always_comb begin
            if (ZERO_REG != 0 && a == ZERO_IDX) begin
                src = SRC_ZERO;
            end else if (BYPASS != 0 && wen && waddr == a) begin
                src = SRC_BYPASS;
            end else begin
                src = SRC_ARRAY;
            end
        end

        // A bypassed read is final if the writeback in flight is the only one outstanding.
        always_comb begin
            port_data  = rf_q[a];
            port_valid = (cnt[a] == '0);
            case (src)
                SRC_ZERO: begin
                    port_data  = '0;
                    port_valid = 1'b1;
                end
                SRC_BYPASS: begin
                    port_data  = wdata;
                    port_valid = (cnt[a] <= CNT_WIDTH'(1));
                end
                default: begin
                    port_data  = rf_q[a];
                    port_valid = (cnt[a] == '0);
                end
            endcase
        end

        assign rdata[i*DATA_WIDTH +: DATA_WIDTH] = port_data;
        assign rvalid[i]                         = port_valid;
    end

endmodule

// File: tb/tb_ysyx_24070016_regfile_sb.sv
// Self-checking bench for ysyx_24070016_regfile_sb: directed scenarios plus a randomized
// run against an integer-counter reference model. A second instance without forwarding
// shares all inputs so the non-bypass read behaviour is checked on the same traffic.
module tb_ysyx_24070016_regfile_sb;

    localparam int CMAX = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  raddr;
    logic [63:0] rdata, rdata_nb;
    logic [1:0]  rvalid, rvalid_nb;
    logic        wen;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        iss_valid;
    logic [4:0]  iss_rd;
    logic        iss_ready, iss_ready_nb;
    logic        flush;

    int errors = 0;
    int checks = 0;

    // Reference model state: plain data array and integer pending counts.
    logic [31:0] rf_m  [32];
    int          cnt_m [32];

    ysyx_24070016_regfile_sb #(
        .ADDR_WIDTH(5), .DATA_WIDTH(32), .NREAD(2), .CNT_WIDTH(2), .ZERO_REG(1), .BYPASS(1)
    ) u_dut (
        .clk(clk), .rst(rst), .raddr(raddr), .rdata(rdata), .rvalid(rvalid),
        .wen(wen), .waddr(waddr), .wdata(wdata), .iss_valid(iss_valid),
        .iss_rd(iss_rd), .iss_ready(iss_ready), .flush(flush)
    );

    ysyx_24070016_regfile_sb #(
        .ADDR_WIDTH(5), .DATA_WIDTH(32), .NREAD(2), .CNT_WIDTH(2), .ZERO_REG(1), .BYPASS(0)
    ) u_dut_nb (
        .clk(clk), .rst(rst), .raddr(raddr), .rdata(rdata_nb), .rvalid(rvalid_nb),
        .wen(wen), .waddr(waddr), .wdata(wdata), .iss_valid(iss_valid),
        .iss_rd(iss_rd), .iss_ready(iss_ready_nb), .flush(flush)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

    // Apply one clock edge to the model from the current inputs.
    task automatic model_clock();
        int inc_r, dec_r;
        if (rst) begin
            for (int r = 0; r < 32; r++) begin
                rf_m[r]  = '0;
                cnt_m[r] = 0;
            end
            return;
        end
        inc_r = -1;
        dec_r = -1;
        if (iss_valid && iss_rd != 0 && cnt_m[iss_rd] != CMAX) inc_r = int'(iss_rd);
        if (wen && waddr != 0 && cnt_m[waddr] != 0) dec_r = int'(waddr);
        if (wen && waddr != 0) rf_m[waddr] = wdata;
        if (flush) begin
            for (int r = 0; r < 32; r++) cnt_m[r] = 0;
        end else if (inc_r != dec_r) begin
            if (inc_r >= 0) cnt_m[inc_r] = cnt_m[inc_r] + 1;
            if (dec_r >= 0) cnt_m[dec_r] = cnt_m[dec_r] - 1;
        end
    endtask

    // Expected read result for index a, with or without forwarding.
    function automatic void model_read(input logic [4:0] a, input bit byp,
                                       output logic [31:0] d, output logic v);
        if (a == 0) begin
            d = '0; v = 1'b1;
        end else if (byp && wen && waddr == a) begin
            d = wdata; v = (cnt_m[a] <= 1);
        end else begin
            d = rf_m[a]; v = (cnt_m[a] == 0);
        end
    endfunction

    task automatic step();
        model_clock();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rst = 1'b0; raddr = '0; wen = 1'b0; waddr = '0; wdata = '0;
        iss_valid = 1'b0; iss_rd = '0; flush = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1; wen = 1'b1; waddr = 5'd3; wdata = 32'h5A5A5A5A;
        step();
        idle();
        for (int idx = 0; idx < 32; idx++) begin
            raddr = {5'(idx), 5'(idx)};
            iss_rd = 5'(idx);
            #1;
            checks++;
            if ({rdata, rvalid, iss_ready} !== {64'h0, 2'b11, 1'b1}) begin
                errors++;
                $display("FAIL reset idx=%0d: rdata=%h rvalid=%b iss_ready=%b, want 0/11/1",
                         idx, rdata, rvalid, iss_ready);
            end
            checks++;
            if ({rdata_nb, rvalid_nb} !== {64'h0, 2'b11}) begin
                errors++;
                $display("FAIL reset_nb idx=%0d: rdata=%h rvalid=%b, want 0/11", idx, rdata_nb, rvalid_nb);
            end
            step();
        end
    endtask

    task automatic test_write_read();
        idle();
        wen = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF;
        step();
        idle();
        raddr = {5'd0, 5'd5};
        #1;
        checks++;
        if ({rdata[31:0], rvalid[0]} !== {32'hDEADBEEF, 1'b1}) begin
            errors++;
            $display("FAIL write_read r5: rdata0=%h rvalid0=%b, want deadbeef/1", rdata[31:0], rvalid[0]);
        end
        wen = 1'b1; waddr = 5'd0; wdata = 32'hFFFFFFFF;
        raddr = {5'd0, 5'd0};
        #1;
        checks++;
        if ({rdata, rvalid} !== {64'h0, 2'b11}) begin
            errors++;
            $display("FAIL write_r0_bypass: rdata=%h rvalid=%b, want 0/11", rdata, rvalid);
        end
        step();
        idle();
        raddr = {5'd0, 5'd0};
        #1;
        checks++;
        if ({rdata, rvalid} !== {64'h0, 2'b11}) begin
            errors++;
            $display("FAIL write_r0_after: rdata=%h rvalid=%b, want 0/11", rdata, rvalid);
        end
    endtask

    task automatic test_scoreboard();
        idle();
        iss_valid = 1'b1; iss_rd = 5'd7;
        #1;
        checks++;
        if (iss_ready !== 1'b1) begin
            errors++;
            $display("FAIL sb_issue_ready: iss_ready=%b, want 1", iss_ready);
        end
        step();
        idle();
        raddr = {5'd7, 5'd0};
        #1;
        checks++;
        if ({rvalid[1], rvalid_nb[1]} !== 2'b00) begin
            errors++;
            $display("FAIL sb_pending: rvalid1=%b rvalid1_nb=%b, want 0/0", rvalid[1], rvalid_nb[1]);
        end
        wen = 1'b1; waddr = 5'd7; wdata = 32'h11;
        #1;
        checks++;
        if ({rdata[63:32], rvalid[1]} !== {32'h11, 1'b1}) begin
            errors++;
            $display("FAIL sb_bypass: rdata1=%h rvalid1=%b, want 11/1", rdata[63:32], rvalid[1]);
        end
        checks++;
        if ({rdata_nb[63:32], rvalid_nb[1]} !== {32'h0, 1'b0}) begin
            errors++;
            $display("FAIL sb_nobypass: rdata1=%h rvalid1=%b, want 0/0", rdata_nb[63:32], rvalid_nb[1]);
        end
        step();
        idle();
        raddr = {5'd7, 5'd0};
        #1;
        checks++;
        if ({rdata[63:32], rvalid[1], rdata_nb[63:32], rvalid_nb[1]} !== {32'h11, 1'b1, 32'h11, 1'b1}) begin
            errors++;
            $display("FAIL sb_released: rdata1=%h/%h rvalid1=%b/%b, want 11/1 on both",
                     rdata[63:32], rdata_nb[63:32], rvalid[1], rvalid_nb[1]);
        end
    endtask

    task automatic test_saturation();
        idle();
        iss_valid = 1'b1; iss_rd = 5'd3;
        for (int k = 0; k < 3; k++) step();
        #1;
        checks++;
        if (iss_ready !== 1'b0) begin
            errors++;
            $display("FAIL sat_full: iss_ready=%b, want 0", iss_ready);
        end
        step();
        idle();
        raddr = {5'd3, 5'd3};
        for (int k = 0; k < 3; k++) begin
            wen = 1'b1; waddr = 5'd3; wdata = 32'h300 + 32'(k);
            step();
            idle();
            raddr = {5'd3, 5'd3};
            #1;
            checks++;
            if (rvalid !== ((k == 2) ? 2'b11 : 2'b00)) begin
                errors++;
                $display("FAIL sat_wb%0d: rvalid=%b, want %b", k, rvalid, (k == 2) ? 2'b11 : 2'b00);
            end
        end
        wen = 1'b1; waddr = 5'd3; wdata = 32'h3FF;
        step();
        idle();
        raddr = {5'd3, 5'd3}; iss_rd = 5'd3;
        #1;
        checks++;
        if ({rdata[31:0], rvalid, iss_ready} !== {32'h3FF, 2'b11, 1'b1}) begin
            errors++;
            $display("FAIL sat_extra_wb: rdata0=%h rvalid=%b iss_ready=%b, want 3ff/11/1",
                     rdata[31:0], rvalid, iss_ready);
        end
        iss_valid = 1'b1; iss_rd = 5'd0;
        for (int k = 0; k < 4; k++) begin
            #1;
            checks++;
            if (iss_ready !== 1'b1) begin
                errors++;
                $display("FAIL sat_r0_ready%0d: iss_ready=%b, want 1", k, iss_ready);
            end
            step();
        end
        idle();
        raddr = {5'd0, 5'd0};
        #1;
        checks++;
        if ({rdata, rvalid} !== {64'h0, 2'b11}) begin
            errors++;
            $display("FAIL sat_r0_read: rdata=%h rvalid=%b, want 0/11", rdata, rvalid);
        end
    endtask

    task automatic test_simultaneous();
        idle();
        iss_valid = 1'b1; iss_rd = 5'd9;
        step();
        idle();
        wen = 1'b1; waddr = 5'd9; wdata = 32'hCAFE0009;
        iss_valid = 1'b1; iss_rd = 5'd9; raddr = {5'd0, 5'd9};
        #1;
        checks++;
        if ({rdata[31:0], rvalid[0]} !== {32'hCAFE0009, 1'b1}) begin
            errors++;
            $display("FAIL simul_bypass: rdata0=%h rvalid0=%b, want cafe0009/1", rdata[31:0], rvalid[0]);
        end
        step();
        idle();
        raddr = {5'd0, 5'd9};
        #1;
        checks++;
        if ({rdata[31:0], rvalid[0]} !== {32'hCAFE0009, 1'b0}) begin
            errors++;
            $display("FAIL simul_next: rdata0=%h rvalid0=%b, want cafe0009/0", rdata[31:0], rvalid[0]);
        end
        wen = 1'b1; waddr = 5'd9; wdata = 32'h99;
        step();
        idle();
        raddr = {5'd0, 5'd9};
        #1;
        checks++;
        if ({rdata[31:0], rvalid[0]} !== {32'h99, 1'b1}) begin
            errors++;
            $display("FAIL simul_release: rdata0=%h rvalid0=%b, want 99/1", rdata[31:0], rvalid[0]);
        end
    endtask

    task automatic test_flush_reset();
        idle();
        iss_valid = 1'b1; iss_rd = 5'd4; step();
        iss_rd = 5'd8; step();
        idle();
        flush = 1'b1; iss_valid = 1'b1; iss_rd = 5'd4;
        wen = 1'b1; waddr = 5'd8; wdata = 32'h22;
        step();
        idle();
        raddr = {5'd8, 5'd4};
        #1;
        checks++;
        if ({rdata[63:32], rvalid} !== {32'h22, 2'b11}) begin
            errors++;
            $display("FAIL flush: rdata1=%h rvalid=%b, want 22/11", rdata[63:32], rvalid);
        end
        iss_valid = 1'b1; iss_rd = 5'd4; step();
        iss_rd = 5'd8; step();
        idle();
        rst = 1'b1; wen = 1'b1; waddr = 5'd8; wdata = 32'h33;
        step();
        idle();
        raddr = {5'd8, 5'd4};
        #1;
        checks++;
        if ({rdata, rvalid} !== {64'h0, 2'b11}) begin
            errors++;
            $display("FAIL reset_midop: rdata=%h rvalid=%b, want 0/11", rdata, rvalid);
        end
        raddr = {5'd7, 5'd5};
        #1;
        checks++;
        if (rdata !== 64'h0) begin
            errors++;
            $display("FAIL reset_data: rdata=%h, want 0", rdata);
        end
    endtask

    task automatic test_random();
        logic [31:0] d;
        logic        v;
        logic [4:0]  a;
        idle();
        for (int n = 0; n < 400; n++) begin
            raddr     = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            wen       = ($urandom_range(0, 1) == 1);
            waddr     = 5'($urandom_range(0, 7));
            wdata     = $urandom;
            iss_valid = ($urandom_range(0, 1) == 1);
            iss_rd    = 5'($urandom_range(0, 7));
            flush     = ($urandom_range(0, 31) == 0);
            #1;
            for (int p = 0; p < 2; p++) begin
                a = raddr[p*5 +: 5];
                model_read(a, 1'b1, d, v);
                checks++;
                if ({rdata[p*32 +: 32], rvalid[p]} !== {d, v}) begin
                    errors++;
                    $display("FAIL rand_byp n=%0d port=%0d a=%0d: got %h/%b want %h/%b",
                             n, p, a, rdata[p*32 +: 32], rvalid[p], d, v);
                end
                model_read(a, 1'b0, d, v);
                checks++;
                if ({rdata_nb[p*32 +: 32], rvalid_nb[p]} !== {d, v}) begin
                    errors++;
                    $display("FAIL rand_nobyp n=%0d port=%0d a=%0d: got %h/%b want %h/%b",
                             n, p, a, rdata_nb[p*32 +: 32], rvalid_nb[p], d, v);
                end
            end
            checks++;
            if (iss_ready !== (iss_rd == 0 || cnt_m[iss_rd] != CMAX)) begin
                errors++;
                $display("FAIL rand_ready n=%0d rd=%0d: got %b want %b",
                         n, iss_rd, iss_ready, (iss_rd == 0 || cnt_m[iss_rd] != CMAX));
            end
            step();
        end
        idle();
    endtask

    initial begin
        idle();
        test_reset();
        test_write_read();
        test_scoreboard();
        test_saturation();
        test_simultaneous();
        test_flush_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
